mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequencer that computes a W x W unsigned product with one shared combinational 4x4 tree
//  multiplier core. It splits both operands into 4-bit digits and issues one digit pair per
//  cycle to the core, accumulating the shifted 8-bit partial products.
//  It sits between a valid/ready operand source and a valid/ready result sink.
// PARAMETERS
//  W      8   operand width; multiple of 4, >= 4
//  D      W/4 derived, local: digits per operand; a run issues D*D core passes
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    operand pair offered
//  in_ready   out  1    block can accept operands
//  in_a       in   W    multiplicand, unsigned
//  in_b       in   W    multiplier, unsigned
//  out_valid  out  1    product available
//  out_ready  in   1    sink accepts product
//  out_p      out  2W   product in_a*in_b, unsigned
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  States: IDLE, RUN, DONE. On reset: IDLE, acc=0, i=j=0, out_valid=0, out_p=0, busy=0.
//  - in_ready = (state==IDLE). It is 0 in RUN and DONE. Offers made in those states are
//    ignored and produce no state change.
//  - IDLE, accept (in_valid & in_ready):
//    latch a=in_a and b=in_b, set acc=0 and i=j=0.
//    If a==0 or b==0, go to DONE (zero shortcut). Otherwise go to RUN.
//  - RUN, every cycle:
//    core x = a[4i+3:4i], core y = b[4j+3:4j];
//    acc <= acc + (core_o << 4*(i+j)), with all widths taken as 2W.
//    j increments; when j wraps from D-1 to 0, i increments.
//    In the cycle where i=j=D-1, go to DONE.
//    acc never overflows 2W, because the final product is < 2^(2W).
//  - DONE: out_valid=1 and out_p=acc. Both stay stable until out_ready.
//    On out_valid & out_ready, go to IDLE. The next operand is accepted no earlier than the
//    following cycle.
//  - Latency from accept edge to out_valid: D*D cycles (4 for W=8); 1 cycle on the zero
//    shortcut.
//  - Throughput: one product per D*D+2 cycles when out_ready is tied high.
//  - Core inputs are driven to 0 outside RUN.
//  - out_p is registered and holds its last value in IDLE. Sinks must qualify it with
//    out_valid.
//  - When rst is asserted in RUN or DONE, the block returns to IDLE immediately and the
//    result is dropped: out_valid falls asynchronously and no partial product is emitted.
//  - If out_ready is high on the cycle DONE is entered, the handshake completes in that
//    cycle: out_valid is high for exactly one cycle.
// STRUCTURE
//  - Package mult_seq_pkg holds: DIGIT_W=4; the state typedef (IDLE/RUN/DONE); a function
//    for digit-select width.
//  - One sub-module: mult4_tree_core (combinational 4x4 -> 8-bit tree multiplier,
//    ports x[3:0], y[3:0], o[7:0]). It is instantiated exactly once; this block is its only
//    driver.
//  - Local logic: FSM, digit counters i/j ($clog2(D) bits each, minimum 1), 2W
//    accumulator, operand registers.
// TESTING
//  1. W=8: accept a=0x12, b=0x34, out_ready=1.
//     -> out_valid rises 4 cycles after accept; out_p=0x03A8; valid for 1 cycle.
//  2. W=8: a=0xFF, b=0xFF.
//     -> out_p=0xFE01 after 4 cycles; exactly 4 RUN cycles observed on the core inputs.
//  3. W=8: a=0x00, b=0x5A.
//     -> zero shortcut: out_valid 1 cycle after accept; out_p=0x0000; no RUN cycle.
//  4. Backpressure: a=0x0F, b=0xF0, out_ready low for 3 cycles after out_valid.
//     -> out_p=0x0E10 stable; in_ready=0 throughout; IDLE on the first out_ready.
//     A new in_valid offered during RUN is not accepted.
//  5. Reset mid-operation: assert rst 2 cycles after accepting 0xAB x 0xCD.
//     -> out_valid never rises; state IDLE, in_ready=1 after release.
//     A following 0x03 x 0x05 gives 0x000F.
//  6. W=16: a=0xFFFF, b=0xFFFF.
//     -> out_p=0xFFFE0001 after 16 cycles.
//     Then a=0x1234, b=0x0001 -> out_p=0x00001234.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the digit-serial multiplier sequencer.
//   DIGIT_W      width of one operand digit fed to the 4x4 core
//   state_t      sequencer states
//   digit_cnt_w  width of a digit counter for a given digit count (never below 1)
package mult_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digit_cnt_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/mult4_tree_core.sv
// Combinational 4x4 -> 8-bit unsigned tree multiplier.
//   x  in   4  multiplicand digit
//   y  in   4  multiplier digit
//   o  out  8  x*y
// Four shifted partial-product rows are reduced by a two-level adder tree.
module mult4_tree_core (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  logic [7:0] pp0;
  logic [7:0] pp1;
  logic [7:0] pp2;
  logic [7:0] pp3;
  logic [7:0] sum_lo;
  logic [7:0] sum_hi;

  assign pp0 = y[0] ? {4'b0000, x}       : 8'h00;
  assign pp1 = y[1] ? {3'b000, x, 1'b0}  : 8'h00;
  assign pp2 = y[2] ? {2'b00, x, 2'b00}  : 8'h00;
  assign pp3 = y[3] ? {1'b0, x, 3'b000}  : 8'h00;

  assign sum_lo = pp0 + pp1;
  assign sum_hi = pp2 + pp3;
  assign o      = sum_lo + sum_hi;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Digit-serial W x W unsigned multiplier built around one shared 4x4 core.
// Operands are split into 4-bit digits; one digit pair is multiplied per
// cycle and the shifted partial products are summed into a 2W accumulator.
//
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    operand pair offered
//   in_ready   out  1    high only in IDLE
//   in_a       in   W    multiplicand
//   in_b       in   W    multiplier
//   out_valid  out  1    product available (DONE)
//   out_ready  in   1    sink accepts product
//   out_p      out  2W   registered product; holds last value in IDLE
//   busy       out  1    high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one digit pair per cycle through the core, accumulating
// DONE  | product presented on out_p, waiting for out_ready
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int D  = W / DIGIT_W;
  localparam int CW = digit_cnt_w(D);
  localparam int PW = 2 * W;
  // wide enough for 4*(i+j) at the largest digit indices
  localparam int SW = CW + 3;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  out_p_q, out_p_d;
  logic [CW-1:0]  i_q, i_d;
  logic [CW-1:0]  j_q, j_d;

  logic [DIGIT_W-1:0] a_digits [D];
  logic [DIGIT_W-1:0] b_digits [D];
  logic [DIGIT_W-1:0] core_x;
  logic [DIGIT_W-1:0] core_y;
  logic [7:0]         core_o;
  logic [SW-1:0]      sh_amt;
  logic [PW-1:0]      pp_shift;

  for (genvar g = 0; g < D; g++) begin : g_digits
    assign a_digits[g] = a_q[g*DIGIT_W +: DIGIT_W];
    assign b_digits[g] = b_q[g*DIGIT_W +: DIGIT_W];
  end

  // Core sees zeros outside RUN so it does not toggle on stale operands.
  assign core_x = (state_q == RUN) ? a_digits[i_q] : '0;
  assign core_y = (state_q == RUN) ? b_digits[j_q] : '0;

  mult4_tree_core u_core (
    .x (core_x),
    .y (core_y),
    .o (core_o)
  );

  assign sh_amt   = (SW'(i_q) + SW'(j_q)) << 2;
  assign pp_shift = PW'(core_o) << sh_amt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_p_d = out_p_q;
    i_d     = i_q;
    j_d     = j_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          // A zero operand needs no passes through the core.
          if ((in_a == '0) || (in_b == '0)) begin
            out_p_d = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        acc_d = acc_q + pp_shift;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if ((i_q == LAST) && (j_q == LAST)) begin
          i_d     = '0;
          out_p_d = acc_d;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_p_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_p_q <= out_p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = out_p_q;

endmodule
